serial_subtractor: RTL and testbench

// - Bit-serial N-bit subtractor, the inverse operation of the lab's full-adder datapath: D = A - B - Bin.
// - Processes one bit per clock, LSB first, through a single full-subtractor cell with a registered borrow.
// - Controlled by a start/busy/done handshake. Sits beside the adder labs as the sequential arithmetic exercise.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor_full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 105 ++++++++++
 tb/tb_serial_subtractor.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StShift = ST_SHIFT,
        StDone  = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the serial subtractor: start handshake, operands, status and result.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;

    // Requester side
    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout
    );

    // Subtractor side
    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: D = A - B - Bin, with borrow-out.
module serial_subtractor_full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    // Difference bit and borrow: borrow when B exceeds A, or when they match and a borrow comes in
    always_comb begin
        D    = A ^ B ^ Bin;
        Bout = (~A & B) | (~(A ^ B) & Bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first, one full-subtractor cell with a registered borrow.
// start is accepted only in IDLE; done pulses for one cycle with D/Bout valid.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   r_sh_q;
    logic               br_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   d_q;
    logic               bout_q;

    logic               cell_d;
    logic               cell_bout;
    logic [WIDTH-1:0]   r_next;

    serial_subtractor_full_subtractor u_cell (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Bin  (br_q),
        .D    (cell_d),
        .Bout (cell_bout)
    );

    // Result register after inserting the current difference bit at the MSB end
    always_comb begin
        r_next = {cell_d, r_sh_q[WIDTH-1:1]};
    end

    // Control FSM with datapath registers and registered busy/done/result outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            r_sh_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh_q  <= bus.A;
                        b_sh_q  <= bus.B;
                        br_q    <= bus.Bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    br_q   <= cell_bout;
                    r_sh_q <= r_next;
                    a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        // Publish straight from the cell so D/Bout are valid with done
                        d_q     <= r_next;
                        bout_q  <= cell_bout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bus.busy = busy_q;
        bus.done = done_q;
        bus.D    = d_q;
        bus.Bout = bout_q;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed cases plus randomized operations.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected {Bout, D} for every accepted start, oldest first
    logic [W:0] exp_q[$];
    logic [W:0] mon_e;

    // Reference: plain integer subtraction, borrow = result went negative
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
        int diff;
        diff = int'(a) - int'(b) - int'(bin);
        return {(diff < 0), W'(diff)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got D=%0h Bout=%0b, expected no result (t=%0t)",
                         bus.D, bus.Bout, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("result_D", 32'(bus.D), 32'(mon_e[W-1:0]));
                check("result_Bout", 32'(bus.Bout), 32'(mon_e[W]));
            end
        end
    end

    // One operation; optionally pulse start again (ignored) at cycle glitch with other operands
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input int glitch, input logic [W-1:0] ga, input logic [W-1:0] gb);
        int lat;
        int busy_n;
        @(posedge clk);
        #1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        bus.start = 1'b1;
        exp_q.push_back(model(a, b, bin));
        lat    = 0;
        busy_n = 0;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                bus.start = 1'b0;
                bus.A     = W'($urandom);
                bus.B     = W'($urandom);
                bus.Bin   = 1'($urandom);
            end
            if (glitch != 0 && lat == glitch) begin
                bus.start = 1'b1;
                bus.A     = ga;
                bus.B     = gb;
            end
            if (glitch != 0 && lat == glitch + 1) bus.start = 1'b0;
            if (bus.busy) busy_n++;
        end
        bus.start = 1'b0;
        check("done_latency", 32'(lat), 32'd9);
        check("busy_cycles", 32'(busy_n), 32'd8);
        @(posedge clk);
        #1;
        check("done_single_pulse", 32'(bus.done), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int t1;
        int t2;
        int e;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;

        // Reset state
        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_D", 32'(bus.D), 32'd0);
        check("reset_Bout", 32'(bus.Bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_op(8'h5A, 8'h21, 1'b0, 0, 8'h00, 8'h00);
        run_op(8'h10, 8'h20, 1'b0, 0, 8'h00, 8'h00);
        run_op(8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h00);
        run_op(8'hFF, 8'hFF, 1'b0, 0, 8'h00, 8'h00);
        run_op(8'h80, 8'h01, 1'b0, 3, 8'h00, 8'hFF);

        // Asynchronous reset mid-operation discards the partial result
        @(posedge clk);
        #1;
        bus.A     = 8'h5A;
        bus.B     = 8'h21;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_D", 32'(bus.D), 32'd0);
        check("midreset_Bout", 32'(bus.Bout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h03, 8'h01, 1'b0, 0, 8'h00, 8'h00);

        // start held high: back-to-back operations, one per WIDTH+2 cycles
        @(posedge clk);
        #1;
        bus.A     = 8'h09;
        bus.B     = 8'h04;
        bus.Bin   = 1'b0;
        bus.start = 1'b1;
        exp_q.push_back(model(8'h09, 8'h04, 1'b0));
        t1 = -1;
        t2 = -100;
        e  = 0;
        while (e < 40 && t2 < 0) begin
            @(posedge clk);
            #1;
            e++;
            if (bus.done) begin
                if (t1 < 0) begin
                    t1    = e;
                    bus.A = 8'h04;
                    bus.B = 8'h09;
                    exp_q.push_back(model(8'h04, 8'h09, 1'b0));
                end else begin
                    t2 = e;
                end
            end
        end
        bus.start = 1'b0;
        check("held_first_latency", 32'(t1), 32'd9);
        check("held_done_spacing", 32'(t2 - t1), 32'd10);
        repeat (2) @(posedge clk);

        // Randomized operations with random idle gaps and ignored mid-operation starts
        for (int i = 0; i < 40; i++) begin
            int g;
            g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 7)) : 0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), g, W'($urandom), W'($urandom));
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
